// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch unit's memory read port, redirect input,
// enable and decode-side valid/ready handshake into one bundle.
//   master : fetch unit side (drives mem_address/mem_data_in/mem_read_write,
//            inst_valid/inst/inst_pc/fetch_fault)
//   slave  : environment side (memory, branch unit, decode)
interface fetch_unit_if;
  logic        fetch_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_write;
  logic [31:0] mem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  modport master (
    input  fetch_enable,
    output mem_address,
    output mem_data_in,
    output mem_read_write,
    input  mem_data_out,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    output fetch_fault
  );

  modport slave (
    output fetch_enable,
    input  mem_address,
    input  mem_data_in,
    input  mem_read_write,
    output mem_data_out,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for mainmem's combinational read
// port. Holds the fetch PC, captures one word per cycle into a small queue
// and hands words to decode over a valid/ready handshake. Supports PC
// redirect with queue flush and a sticky out-of-window fault flag.
// Ports:
//   clock        sole clock, posedge
//   reset        asynchronous, active-high
//   bus.master   fetch_enable, mem_address/mem_data_in/mem_read_write,
//                mem_data_out, redirect_valid/redirect_pc,
//                inst_valid/inst_ready/inst/inst_pc, fetch_fault
//
// state | meaning
// IDLE  | fetch_enable low; PC holds, queue drains
// FETCH | enabled, queue has room; one capture per cycle
// STALL | enabled, queue full; capture only alongside a dequeue
// FAULT | fetch_pc outside the memory window; waits for redirect/reset
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000,
  parameter int          QUEUE_DEPTH     = 2
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(QUEUE_DEPTH - 1);
  // 33-bit bounds so a window ending near 2^32 cannot wrap into a false pass
  localparam logic [32:0] WIN_LO = {1'b0, STARTING_ADDR};
  localparam logic [32:0] WIN_HI = {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES} - 33'd4;

  typedef enum logic [1:0] {IDLE, FETCH, STALL, FAULT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              fault_q, fault_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       q_pc   [QUEUE_DEPTH];
  logic [31:0]       q_inst [QUEUE_DEPTH];

  logic        in_window;
  logic        q_empty, q_full;
  logic        push, pop, flush;
  logic [32:0] pc_ext;

  always_comb begin
    pc_ext    = {1'b0, fetch_pc_q};
    in_window = (pc_ext >= WIN_LO) && (pc_ext <= WIN_HI);
  end

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == FULL_CNT);
  assign flush   = bus.redirect_valid;
  // a dequeue coincident with a redirect is swallowed by the flush
  assign pop     = !q_empty && bus.inst_ready && !flush;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    push       = 1'b0;
    if (flush) begin
      fetch_pc_d = bus.redirect_pc & ~32'd3;
      fault_d    = 1'b0;
      state_d    = bus.fetch_enable ? FETCH : IDLE;
    end else if (!bus.fetch_enable) begin
      state_d = IDLE;
    end else if (state_q == FAULT || !in_window) begin
      fault_d = 1'b1;
      state_d = FAULT;
    end else begin
      // a full queue can still accept a word when the head leaves this cycle
      push = !q_full || pop;
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      state_d = (q_full || (count_q == ALMOST_CNT && !pop)) ? STALL : FETCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= STARTING_ADDR;
      fault_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // storage needs no reset: outputs are masked while the queue is empty
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr_q]   <= fetch_pc_q;
      q_inst[wr_ptr_q] <= bus.mem_data_out;
    end
  end

  assign bus.mem_address    = fetch_pc_q;
  assign bus.mem_data_in    = 32'd0;
  assign bus.mem_read_write = 1'b0;
  assign bus.inst_valid     = !q_empty;
  assign bus.inst           = q_empty ? 32'd0 : q_inst[rd_ptr_q];
  assign bus.inst_pc        = q_empty ? 32'd0 : q_pc[rd_ptr_q];
  assign bus.fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] START = 32'h0100_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_unit_if bus();

  fetch_unit #(
    .STARTING_ADDR(START),
    .MEM_DEPTH_BYTES(32'h0010_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0100_0000: mem_word = 32'h0000_0013;
      32'h0100_0004: mem_word = 32'h0010_0093;
      32'h0100_0008: mem_word = 32'h0020_0113;
      default:       mem_word = ~a ^ 32'h1234_5678;
    endcase
  endfunction

  assign bus.mem_data_out = mem_word(bus.mem_address);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard monitor: every accepted head is matched against the queue
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      chk("mem_read_write", {31'd0, bus.mem_read_write}, 32'd0);
      chk("mem_data_in", bus.mem_data_in, 32'd0);
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid && !reset) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_delivery: got pc %h inst %h expected none", bus.inst_pc, bus.inst);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc", bus.inst_pc, e.pc);
          chk("deliver_inst", bus.inst, e.word);
        end
      end
    end
  endtask

  task automatic redirect(input logic [31:0] pc, input logic en, input logic rdy);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    bus.fetch_enable   = en;
    bus.inst_ready     = rdy;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.fetch_enable   = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    fork
      monitor();
    join_none

    // reset state
    tick();
    tick();
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("rst_mem_address", bus.mem_address, START);
    reset = 1'b0;

    // streaming, one word per cycle
    expect_word(START);
    expect_word(START + 32'd4);
    expect_word(START + 32'd8);
    bus.fetch_enable = 1'b1;
    bus.inst_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_valid", {31'd0, bus.inst_valid}, 32'd1);
    end
    bus.fetch_enable = 1'b0;
    tick();
    chk("stream_drained", {31'd0, bus.inst_valid}, 32'd0);
    chk("stream_pc", bus.mem_address, START + 32'd12);

    // back-pressure: two captured, head stable, then drain without gap
    redirect(START, 1'b0, 1'b0);
    expect_word(START);
    expect_word(START + 32'd4);
    expect_word(START + 32'd8);
    bus.fetch_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_head_pc", bus.inst_pc, START);
      chk("stall_head_inst", bus.inst, 32'h0000_0013);
    end
    chk("stall_fetch_pc", bus.mem_address, START + 32'd8);
    bus.inst_ready = 1'b1;
    tick();
    bus.fetch_enable = 1'b0;
    chk("release_valid1", {31'd0, bus.inst_valid}, 32'd1);
    tick();
    chk("release_valid2", {31'd0, bus.inst_valid}, 32'd1);
    tick();
    chk("release_empty", {31'd0, bus.inst_valid}, 32'd0);
    chk("release_pc", bus.mem_address, START + 32'd12);

    // redirect while full with a coincident dequeue
    bus.inst_ready   = 1'b0;
    bus.fetch_enable = 1'b1;
    tick();
    tick();
    chk("fill_valid", {31'd0, bus.inst_valid}, 32'd1);
    expect_word(32'h0100_0040);
    redirect(32'h0100_0042, 1'b1, 1'b1);
    chk("flush_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("flush_pc", bus.mem_address, 32'h0100_0040);
    tick();
    bus.fetch_enable = 1'b0;
    chk("redir_first_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("redir_first_pc", bus.inst_pc, 32'h0100_0040);
    tick();

    // run off the top of the window
    expect_word(32'h010F_FFF8);
    expect_word(32'h010F_FFFC);
    redirect(32'h010F_FFF8, 1'b1, 1'b1);
    tick();
    tick();
    chk("edge_no_fault", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    chk("edge_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("edge_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("edge_addr", bus.mem_address, 32'h0110_0000);
    tick();
    tick();
    chk("edge_addr_hold", bus.mem_address, 32'h0110_0000);
    chk("edge_fault_hold", {31'd0, bus.fetch_fault}, 32'd1);
    redirect(START, 1'b0, 1'b1);
    chk("fault_cleared", {31'd0, bus.fetch_fault}, 32'd0);
    chk("fault_clear_addr", bus.mem_address, START);

    // below the window and near 2^32
    redirect(32'h00FF_FFFC, 1'b1, 1'b1);
    chk("low_pre_fault", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    chk("low_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("low_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("low_addr", bus.mem_address, 32'h00FF_FFFC);
    redirect(32'hFFFF_FFFC, 1'b1, 1'b1);
    chk("high_pre_fault", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    chk("high_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("high_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("high_addr", bus.mem_address, 32'hFFFF_FFFC);

    // reset mid-stream with two entries queued
    redirect(START + 32'd16, 1'b1, 1'b0);
    tick();
    tick();
    chk("pre_reset_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("pre_reset_addr", bus.mem_address, START + 32'd24);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("reset_addr", bus.mem_address, START);
    chk("reset_inst_pc", bus.inst_pc, 32'd0);
    bus.fetch_enable = 1'b0;
    bus.inst_ready   = 1'b1;
    tick();
    reset = 1'b0;
    expect_word(START);
    expect_word(START + 32'd4);
    bus.fetch_enable = 1'b1;
    tick();
    tick();
    bus.fetch_enable = 1'b0;
    tick();
    tick();
    chk("restart_addr", bus.mem_address, START + 32'd8);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
